// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Serializes the RAM requests of CPUS instruction caches and CPUS data
//   caches onto a single RAM port. Data requests (dREN/dWEN) always beat
//   instruction fetches (iREN). Ties among CPUs within a class go to the
//   lowest CPU index, or, when ARB_ROUND_ROBIN_EN is defined, to the first
//   requesting CPU after the last completed grant.
//
// Handshake: a requester raises iREN/dREN/dWEN and holds the request,
//   address and store data stable while its wait bit is 1. The cycle in
//   which its wait bit is 0 is the single completion cycle; for reads the
//   matching load slot carries the RAM data in that same cycle only.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN/dREN/dWEN     per-CPU request bits
//   iaddr/daddr/dstore 32 bits per CPU, CPU n at [32n+31:32n]
//   iwait/dwait        per-CPU wait (1 = not complete this cycle)
//   iload/dload        per-CPU read data, zero except on completion
//   ramREN/ramWEN      RAM strobes, ramaddr/ramstore RAM address/data
//   ramload/ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   state_o            debug view of the FSM (0 = IDLE, 1 = GRANT)
//
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module memory_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [32*CPUS-1:0]  iaddr,
  input  logic [32*CPUS-1:0]  daddr,
  input  logic [32*CPUS-1:0]  dstore,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS-1:0]     dwait,
  output logic [32*CPUS-1:0]  iload,
  output logic [32*CPUS-1:0]  dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  logic [1:0]          ramstate,
  output logic                state_o
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e          state_q;
  logic [IW-1:0]   gnt_idx_q;
  logic            gnt_data_q;  // 1 = data class, 0 = instruction class
  logic            gnt_wr_q;    // 1 = write (data class only)
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]   ptr_q;       // CPU of the last completed transfer
`endif

  logic [CPUS-1:0] d_req;
  logic [CPUS-1:0] req_vec;
  logic            win_data;
  logic            win_any;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            live;
  logic            granted;
  logic            done;
  int              gnt_base;

  // Winner selection, only consumed while IDLE.
  always_comb begin
    d_req    = dREN | dWEN;
    win_data = |d_req;
    req_vec  = win_data ? d_req : iREN;
    win_any  = 1'b0;
    win_idx  = '0;
    cand     = '0;
`ifdef ARB_ROUND_ROBIN_EN
    // Search starts one past the pointer and wraps.
    for (int k = 0; k < CPUS; k++) begin
      cand = IW'((int'(ptr_q) + k + 1) % CPUS);
      if (!win_any && req_vec[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
`else
    // Descending scan: the lowest requesting index is written last.
    for (int k = CPUS - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (req_vec[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
`endif
  end

  // The latched op's own request bit decides whether the grant is still
  // alive; dropping it before ACCESS aborts the transfer.
  always_comb begin
    live     = gnt_wr_q   ? dWEN[gnt_idx_q] :
               gnt_data_q ? dREN[gnt_idx_q] : iREN[gnt_idx_q];
    granted  = (state_q == GRANT);
    done     = granted && live && (ramstate == RAM_ACCESS);
    gnt_base = 32 * int'(gnt_idx_q);
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (granted) begin
      ramREN   = !gnt_wr_q;
      ramWEN   = gnt_wr_q;
      ramaddr  = gnt_data_q ? daddr[gnt_base +: 32] : iaddr[gnt_base +: 32];
      ramstore = gnt_wr_q ? dstore[gnt_base +: 32] : '0;
      if (done) begin
        if (gnt_data_q) begin
          dwait[gnt_idx_q] = 1'b0;
          if (!gnt_wr_q) dload[gnt_base +: 32] = ramload;
        end else begin
          iwait[gnt_idx_q] = 1'b0;
          iload[gnt_base +: 32] = ramload;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      gnt_data_q <= 1'b0;
      gnt_wr_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= IW'(CPUS - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q    <= GRANT;
            gnt_idx_q  <= win_idx;
            gnt_data_q <= win_data;
            gnt_wr_q   <= win_data & dWEN[win_idx];
          end
        end
        GRANT: begin
          if (!live) begin
            state_q <= IDLE;
          end else if (ramstate == RAM_ACCESS) begin
            state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= gnt_idx_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam logic [1:0] RS_F = 2'd0;
  localparam logic [1:0] RS_B = 2'd1;
  localparam logic [1:0] RS_A = 2'd2;
  localparam logic [1:0] RS_E = 2'd3;

  logic        CLK;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        state_o;

  int n_cmp;
  int n_err;

  memory_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .state_o(state_o)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ir, dr, dw;
    logic [31:0] rl;
    logic [1:0]  rs;
    logic [1:0]  e_iw, e_dw;
    logic [63:0] e_il, e_dl;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_st;
    logic        e_state;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                       input logic [31:0] rl, input logic [1:0] rs);
    iREN = ir; dREN = dr; dWEN = dw; ramload = rl; ramstate = rs;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " iwait"},    64'(iwait),    64'(v.e_iw));
    chk({tag, " dwait"},    64'(dwait),    64'(v.e_dw));
    chk({tag, " iload"},    iload,         v.e_il);
    chk({tag, " dload"},    dload,         v.e_dl);
    chk({tag, " ramREN"},   64'(ramREN),   64'(v.e_ren));
    chk({tag, " ramWEN"},   64'(ramWEN),   64'(v.e_wen));
    chk({tag, " ramaddr"},  64'(ramaddr),  64'(v.e_addr));
    chk({tag, " ramstore"}, 64'(ramstore), 64'(v.e_st));
    chk({tag, " state"},    64'(state_o),  64'(v.e_state));
  endtask

  initial begin
    vec_t idle_v;
    int   win;
    logic [1:0]  exp_dw;
    logic [63:0] exp_dl;
    n_cmp = 0;
    n_err = 0;

    // Fixed requester addresses/data: CPU1 in upper word, CPU0 in lower.
    iaddr  = {32'h0000_0300, 32'h0000_0100};
    daddr  = {32'h0000_0200, 32'h0000_0240};
    dstore = {32'h0000_1234, 32'h0000_5678};

    // ir, dr, dw, ramload, ramstate | iwait, dwait, iload, dload, REN, WEN, addr, store, state
    // single fetch
    vecs[0]  = '{2'b00, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 32'hDEADBEEF, RS_A, 2'b10, 2'b11, 64'h0000_0000_DEAD_BEEF, 64'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    // data write beats instruction fetch, fetch follows
    vecs[4]  = '{2'b01, 2'b00, 2'b10, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[5]  = '{2'b01, 2'b00, 2'b10, 32'h0,        RS_B, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b1, 32'h200, 32'h1234, 1'b1};
    vecs[6]  = '{2'b01, 2'b00, 2'b10, 32'hAAAA,     RS_A, 2'b11, 2'b01, 64'h0, 64'h0, 1'b0, 1'b1, 32'h200, 32'h1234, 1'b1};
    vecs[7]  = '{2'b01, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[8]  = '{2'b01, 2'b00, 2'b00, 32'hCAFEF00D, RS_A, 2'b10, 2'b11, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    // wait states with ERROR in the middle
    vecs[10] = '{2'b00, 2'b10, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[11] = '{2'b00, 2'b10, 2'b00, 32'h0,        RS_B, 2'b11, 2'b11, 64'h0, 64'h0, 1'b1, 1'b0, 32'h200, 32'h0,    1'b1};
    vecs[12] = '{2'b00, 2'b10, 2'b00, 32'h0,        RS_E, 2'b11, 2'b11, 64'h0, 64'h0, 1'b1, 1'b0, 32'h200, 32'h0,    1'b1};
    vecs[13] = '{2'b00, 2'b10, 2'b00, 32'h0,        RS_B, 2'b11, 2'b11, 64'h0, 64'h0, 1'b1, 1'b0, 32'h200, 32'h0,    1'b1};
    vecs[14] = '{2'b00, 2'b10, 2'b00, 32'h0BADF00D, RS_A, 2'b11, 2'b01, 64'h0, 64'h0BAD_F00D_0000_0000, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1};
    vecs[15] = '{2'b00, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    // abort: granted fetch drops before ACCESS
    vecs[16] = '{2'b10, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[17] = '{2'b10, 2'b00, 2'b00, 32'h0,        RS_B, 2'b11, 2'b11, 64'h0, 64'h0, 1'b1, 1'b0, 32'h300, 32'h0,    1'b1};
    vecs[18] = '{2'b00, 2'b00, 2'b00, 32'h0,        RS_B, 2'b11, 2'b11, 64'h0, 64'h0, 1'b1, 1'b0, 32'h300, 32'h0,    1'b1};
    vecs[19] = '{2'b00, 2'b00, 2'b00, 32'h1111,     RS_A, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    // dREN and dWEN together: write wins
    vecs[20] = '{2'b00, 2'b01, 2'b01, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    vecs[21] = '{2'b00, 2'b01, 2'b01, 32'h9999,     RS_A, 2'b11, 2'b10, 64'h0, 64'h0, 1'b0, 1'b1, 32'h240, 32'h5678, 1'b1};
    vecs[22] = '{2'b00, 2'b00, 2'b00, 32'h0,        RS_F, 2'b11, 2'b11, 64'h0, 64'h0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0};
    idle_v   = vecs[0];

    // Reset state
    nRST = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 32'h0, RS_F);
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset", idle_v);
    @(negedge CLK);
    nRST = 1'b1;

    // Table-driven cycle vectors: inputs applied on the falling edge,
    // outputs sampled 1 time unit later.
    for (int i = 0; i < 23; i++) begin
      @(negedge CLK);
      drive(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].rl, vecs[i].rs);
      #1;
      check_all($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the middle of a grant
    @(negedge CLK);
    drive(2'b10, 2'b00, 2'b00, 32'h0, RS_F);
    #1;
    chk("rst_mid idle", 64'(state_o), 64'(0));
    @(negedge CLK);
    drive(2'b10, 2'b00, 2'b00, 32'h5555, RS_B);
    #1;
    chk("rst_mid granted", 64'(state_o), 64'(1));
    chk("rst_mid ramaddr", 64'(ramaddr), 64'h300);
    #1;
    nRST = 1'b0;
    #1;
    ramstate = RS_A;
    #1;
    check_all("rst_mid asserted", idle_v);
    @(negedge CLK);
    nRST = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 32'h0, RS_F);

    // Both CPUs hold dREN; BUSY, BUSY, ACCESS per transfer.
    @(negedge CLK);
    drive(2'b00, 2'b11, 2'b00, 32'h0, RS_F);
    #1;
    chk("rr idle0", 64'(state_o), 64'(0));
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = t % 2;
`else
      win = 0;
`endif
      for (int w = 0; w < 3; w++) begin
        @(negedge CLK);
        drive(2'b00, 2'b11, 2'b00, 32'hD000_0000 + 32'(t), (w < 2) ? RS_B : RS_A);
        #1;
        chk($sformatf("rr t%0d w%0d ramaddr", t, w), 64'(ramaddr), (win == 0) ? 64'h240 : 64'h200);
        chk($sformatf("rr t%0d w%0d ramREN", t, w), 64'(ramREN), 64'(1));
        exp_dw = 2'b11;
        exp_dl = 64'h0;
        if (w == 2) begin
          exp_dw[win] = 1'b0;
          exp_dl = (win == 0) ? {32'h0, 32'hD000_0000 + 32'(t)} : {32'hD000_0000 + 32'(t), 32'h0};
        end
        chk($sformatf("rr t%0d w%0d dwait", t, w), 64'(dwait), 64'(exp_dw));
        chk($sformatf("rr t%0d w%0d dload", t, w), dload, exp_dl);
      end
      // Held requests are re-arbitrated in the IDLE cycle after completion.
      @(negedge CLK);
      drive(2'b00, 2'b11, 2'b00, 32'h0, RS_F);
      #1;
      chk($sformatf("rr t%0d idle", t), 64'(state_o), 64'(0));
      chk($sformatf("rr t%0d idle dwait", t), 64'(dwait), 64'(2'b11));
    end

    @(negedge CLK);
    drive(2'b00, 2'b00, 2'b00, 32'h0, RS_F);
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
